atm_account_db: RTL and testbench

- Account store and authentication responder for the ATM controller. It holds a PIN, balance, wrong-PIN counter and lock flag for each of NUM_ACCOUNTS accounts.
- It answers the controller's auth, read and commit requests, supplying wrong_psw and current_balance and accepting the updated balance.
- It sits between the ATM FSM and the provisioning/test interface.

---
 rtl/atm_account_db.sv | 178 +++++++++++++++++
 tb/tb_atm_account_db.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/atm_account_db.sv
// Per-account PIN/balance/lock store with a 3-state request responder (IDLE, LOOKUP, RESP).
// One request every three cycles; response outputs hold until the next RESP.
module atm_account_db #(
    parameter int BALANCE_WIDTH = 20,
    parameter int PIN_WIDTH     = 16,
    parameter int NUM_ACCOUNTS  = 8,
    parameter int ID_WIDTH      = 3,
    parameter int MAX_TRIES     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic [1:0]               cmd,
    input  logic [ID_WIDTH-1:0]      acct_id,
    input  logic [PIN_WIDTH-1:0]     pin_in,
    input  logic [BALANCE_WIDTH-1:0] wr_balance,
    input  logic                     session_end,
    output logic                     busy,
    output logic                     done,
    output logic [BALANCE_WIDTH-1:0] current_balance,
    output logic                     wrong_psw,
    output logic                     locked,
    output logic                     cmd_error
);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

    localparam logic [1:0] CMD_AUTH   = 2'b00;
    localparam logic [1:0] CMD_READ   = 2'b01;
    localparam logic [1:0] CMD_COMMIT = 2'b10;
    localparam logic [1:0] MAX_CNT    = 2'(MAX_TRIES);

    state_t                     state;
    logic [1:0]                 cmd_p0;
    logic [ID_WIDTH-1:0]        id_p0;
    logic [PIN_WIDTH-1:0]       pin_p0;
    logic [BALANCE_WIDTH-1:0]   bal_p0;

    logic [PIN_WIDTH-1:0]       pin_mem  [NUM_ACCOUNTS];
    logic [BALANCE_WIDTH-1:0]   bal_mem  [NUM_ACCOUNTS];
    logic [1:0]                 cnt_mem  [NUM_ACCOUNTS];
    logic                       lock_mem [NUM_ACCOUNTS];

    logic                       sess_valid;
    logic [ID_WIDTH-1:0]        sess_id;

    logic                       id_ok;
    logic                       sess_ok;
    logic [PIN_WIDTH-1:0]       cur_pin;
    logic [BALANCE_WIDTH-1:0]   cur_bal;
    logic [1:0]                 cur_cnt;
    logic                       cur_lock;
    logic [1:0]                 cnt_inc;

    // Fail counter never wraps: it stops at the lock threshold.
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c >= MAX_CNT) ? MAX_CNT : c + 2'd1;
    endfunction

    assign id_ok    = (int'(id_p0) < NUM_ACCOUNTS);
    assign sess_ok  = sess_valid && (sess_id == id_p0);
    assign cur_pin  = pin_mem[id_p0];
    assign cur_bal  = bal_mem[id_p0];
    assign cur_cnt  = cnt_mem[id_p0];
    assign cur_lock = lock_mem[id_p0];
    assign cnt_inc  = sat_inc(cur_cnt);

    // Request capture at the accepting edge
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            cmd_p0 <= cmd;
            id_p0  <= acct_id;
            pin_p0 <= pin_in;
            bal_p0 <= wr_balance;
        end
    end

    // Lookup/update at LOOKUP->RESP, response registered on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            current_balance <= '0;
            wrong_psw       <= 1'b0;
            locked          <= 1'b0;
            cmd_error       <= 1'b0;
            sess_valid      <= 1'b0;
            sess_id         <= '0;
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                pin_mem[i]  <= '0;
                bal_mem[i]  <= '0;
                cnt_mem[i]  <= '0;
                lock_mem[i] <= 1'b0;
            end
        end else begin
            // A successful AUTH below overrides a coincident session_end.
            if (session_end) sess_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        state <= LOOKUP;
                        busy  <= 1'b1;
                    end
                end
                LOOKUP: begin
                    state           <= RESP;
                    done            <= 1'b1;
                    current_balance <= '0;
                    wrong_psw       <= 1'b0;
                    locked          <= 1'b0;
                    cmd_error       <= 1'b0;
                    if (!id_ok) begin
                        cmd_error <= 1'b1;
                    end else begin
                        unique case (cmd_p0)
                            CMD_AUTH: begin
                                if (cur_lock) begin
                                    wrong_psw <= 1'b1;
                                    locked    <= 1'b1;
                                end else if (cur_pin == pin_p0) begin
                                    cnt_mem[id_p0]  <= '0;
                                    sess_valid      <= 1'b1;
                                    sess_id         <= id_p0;
                                    current_balance <= cur_bal;
                                end else begin
                                    wrong_psw      <= 1'b1;
                                    cnt_mem[id_p0] <= cnt_inc;
                                    sess_valid     <= 1'b0;
                                    if (cnt_inc == MAX_CNT) begin
                                        lock_mem[id_p0] <= 1'b1;
                                        locked          <= 1'b1;
                                    end
                                end
                            end
                            CMD_READ: begin
                                if (sess_ok) begin
                                    current_balance <= cur_bal;
                                    locked          <= cur_lock;
                                end else begin
                                    cmd_error <= 1'b1;
                                end
                            end
                            CMD_COMMIT: begin
                                if (sess_ok) begin
                                    bal_mem[id_p0]  <= bal_p0;
                                    current_balance <= bal_p0;
                                    locked          <= cur_lock;
                                end else begin
                                    cmd_error <= 1'b1;
                                end
                            end
                            default: begin
                                pin_mem[id_p0]  <= pin_p0;
                                bal_mem[id_p0]  <= bal_p0;
                                cnt_mem[id_p0]  <= '0;
                                lock_mem[id_p0] <= 1'b0;
                                current_balance <= bal_p0;
                                if (sess_id == id_p0) sess_valid <= 1'b0;
                            end
                        endcase
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_account_db.sv
// Randomized bench for atm_account_db (6 accounts) against a request-level account model,
// with directed scenarios pinned by hand-computed values.
module tb_atm_account_db;

    localparam int NA   = 6;
    localparam int MAXT = 3;
    localparam logic [1:0] AUTH = 2'd0, READ = 2'd1, COMMIT = 2'd2, PROV = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  cmd = '0;
    logic [2:0]  acct_id = '0;
    logic [15:0] pin_in = '0;
    logic [19:0] wr_balance = '0;
    logic        session_end = 1'b0;
    logic        busy, done, wrong_psw, locked, cmd_error;
    logic [19:0] current_balance;

    atm_account_db #(
        .BALANCE_WIDTH(20), .PIN_WIDTH(16), .NUM_ACCOUNTS(NA), .ID_WIDTH(3), .MAX_TRIES(MAXT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .acct_id(acct_id), .pin_in(pin_in),
        .wr_balance(wr_balance), .session_end(session_end), .busy(busy), .done(done),
        .current_balance(current_balance), .wrong_psw(wrong_psw), .locked(locked),
        .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    // Model of the account store and session
    int m_pin [NA];
    int m_bal [NA];
    int m_cnt [NA];
    bit m_lock [NA];
    bit m_sv;
    int m_sid;

    // Expected outputs, compared every cycle
    int e_busy = 0, e_done = 0, e_bal = 0, e_wp = 0, e_lk = 0, e_err = 0;
    bit chk_en = 1'b1;
    int n_chk = 0, n_pass = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (chk_en) begin
            chk("busy", int'(busy), e_busy);
            chk("done", int'(done), e_done);
            chk("current_balance", int'(current_balance), e_bal);
            chk("wrong_psw", int'(wrong_psw), e_wp);
            chk("locked", int'(locked), e_lk);
            chk("cmd_error", int'(cmd_error), e_err);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin
            m_pin[i] = 0; m_bal[i] = 0; m_cnt[i] = 0; m_lock[i] = 1'b0;
        end
        m_sv = 1'b0; m_sid = 0;
        e_busy = 0; e_done = 0; e_bal = 0; e_wp = 0; e_lk = 0; e_err = 0;
    endtask

    task automatic model(input logic [1:0] c, input int id, input int p, input int b, input bit se);
        e_bal = 0; e_wp = 0; e_lk = 0; e_err = 0;
        if (id >= NA) begin
            e_err = 1;
        end else begin
            case (c)
                AUTH: begin
                    if (m_lock[id]) begin
                        e_wp = 1; e_lk = 1;
                        if (se) m_sv = 1'b0;
                    end else if (p == m_pin[id]) begin
                        m_cnt[id] = 0; m_sv = 1'b1; m_sid = id; e_bal = m_bal[id];
                    end else begin
                        m_cnt[id] = (m_cnt[id] + 1 > MAXT) ? MAXT : m_cnt[id] + 1;
                        e_wp = 1; m_sv = 1'b0;
                        if (m_cnt[id] >= MAXT) begin m_lock[id] = 1'b1; e_lk = 1; end
                    end
                end
                READ: begin
                    if (m_sv && m_sid == id) begin e_bal = m_bal[id]; e_lk = int'(m_lock[id]); end
                    else e_err = 1;
                end
                COMMIT: begin
                    if (m_sv && m_sid == id) begin
                        m_bal[id] = b; e_bal = b; e_lk = int'(m_lock[id]);
                    end else e_err = 1;
                end
                default: begin
                    m_pin[id] = p; m_bal[id] = b; m_cnt[id] = 0; m_lock[id] = 1'b0; e_bal = b;
                    if (m_sid == id) m_sv = 1'b0;
                end
            endcase
        end
    endtask

    // se_mode: 0 none, 1 session_end on the accepting edge, 2 on the LOOKUP->RESP edge (AUTH only)
    task automatic issue(input logic [1:0] c, input int id, input int p, input int b,
                         input int se_mode, input bit hold);
        req = 1'b1; cmd = c; acct_id = 3'(id); pin_in = 16'(p); wr_balance = 20'(b);
        session_end = (se_mode == 1);
        @(posedge clk); #1;
        if (se_mode == 1) m_sv = 1'b0;
        if (!hold) req = 1'b0;
        session_end = (se_mode == 2);
        e_busy = 1;
        @(posedge clk); #1;
        session_end = 1'b0;
        model(c, id, p, b, se_mode == 2);
        e_done = 1;
        @(posedge clk); #1;
        req = 1'b0; e_done = 0; e_busy = 0;
    endtask

    task automatic pulse_se();
        session_end = 1'b1;
        @(posedge clk); #1;
        session_end = 1'b0; m_sv = 1'b0;
    endtask

    task automatic lit(input string nm, input int wp, input int lk, input int err, input int bal);
        chk({nm, "_wrong_psw"}, int'(wrong_psw), wp);
        chk({nm, "_locked"}, int'(locked), lk);
        chk({nm, "_cmd_error"}, int'(cmd_error), err);
        chk({nm, "_balance"}, int'(current_balance), bal);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Provision and good AUTH
        issue(PROV, 3, 5, 77, 0, 0);
        issue(PROV, 2, 'h1234, 500, 0, 0);
        issue(AUTH, 2, 'h1234, 0, 0, 0);
        lit("auth_ok", 0, 0, 0, 500);
        chk("model_auth_bal", e_bal, 500);

        // Three wrong PINs lock the account; correct PIN then refused; PROVISION unlocks
        issue(AUTH, 2, 0, 0, 0, 0);  lit("bad1", 1, 0, 0, 0);
        issue(AUTH, 2, 0, 0, 0, 0);  lit("bad2", 1, 0, 0, 0);
        issue(AUTH, 2, 0, 0, 0, 0);  lit("bad3", 1, 1, 0, 0);
        issue(AUTH, 2, 'h1234, 0, 0, 0); lit("locked_auth", 1, 1, 0, 0);
        issue(PROV, 2, 'h1234, 500, 0, 0);
        issue(AUTH, 2, 'h1234, 0, 0, 0); lit("unlocked", 0, 0, 0, 500);

        // COMMIT / READ within session, COMMIT to another account refused
        issue(COMMIT, 2, 0, 350, 0, 0); lit("commit", 0, 0, 0, 350);
        issue(READ, 2, 0, 0, 0, 0);     lit("read", 0, 0, 0, 350);
        issue(COMMIT, 3, 0, 9, 0, 0);   lit("commit_other", 0, 0, 1, 0);

        // session_end invalidates; coincident with AUTH result it loses
        pulse_se();
        issue(READ, 2, 0, 0, 0, 0);     lit("read_ended", 0, 0, 1, 0);
        issue(AUTH, 2, 'h1234, 0, 2, 0);
        issue(READ, 2, 0, 0, 0, 0);     lit("read_after_se_auth", 0, 0, 0, 350);
        issue(AUTH, 3, 5, 0, 0, 0);     lit("id3_unchanged", 0, 0, 0, 77);

        // Out-of-range id, req held while busy
        issue(AUTH, 7, 0, 0, 0, 0);     lit("bad_id", 0, 0, 1, 0);
        d0 = done_cnt;
        issue(READ, 3, 0, 0, 0, 1);
        repeat (3) @(posedge clk);
        #1 chk("one_done_for_held_req", done_cnt - d0, 1);

        // Reset during LOOKUP of a COMMIT of 999
        req = 1'b1; cmd = COMMIT; acct_id = 3'd3; wr_balance = 20'd999;
        @(posedge clk); #1;
        req = 1'b0; e_busy = 1;
        rst = 1'b0; model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1 chk("no_done_after_reset", done_cnt - d0, 0);
        lit("after_reset", 0, 0, 0, 0);
        issue(AUTH, 3, 0, 0, 0, 0);     lit("auth_zero_pin", 0, 0, 0, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r, id, p, b, se;
            logic [1:0] c;
            r = $urandom_range(0, 99);
            c = (r < 35) ? AUTH : (r < 60) ? READ : (r < 85) ? COMMIT : PROV;
            r = $urandom_range(0, 9);
            id = (r > 7) ? m_sid : r;
            r = $urandom_range(0, 3);
            p = (r == 0 && id < NA) ? m_pin[id] : (r == 1) ? 0 : int'($urandom_range(0, 65535));
            b = int'($urandom_range(0, 1048575));
            r = $urandom_range(0, 9);
            se = (r == 0) ? 1 : (r == 1 && c == AUTH) ? 2 : 0;
            issue(c, id, p, b, se, $urandom_range(0, 7) == 0);
            r = $urandom_range(0, 5);
            if (r == 0) pulse_se();
            else if (r == 1) begin @(posedge clk); #1; end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
